ddr2_host_sequencer: RTL and testbench

//  Host-side traffic master for ddr2_controller: drives its cmd/addr/din/initddr inputs and pops its return FIFO.
//  On start: brings up DDR2 init if needed, writes a seeded pattern to a linear address range, reads it back,

---
 rtl/ddr2_host_sequencer_if.sv | 27 ++
 rtl/ddr2_host_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_ddr2_host_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr2_host_sequencer_if.sv
// Host-side bus between the traffic sequencer (master) and the DDR2 controller (slave):
// the command/write path plus the return FIFO pop path.
interface ddr2_host_sequencer_if #(
   parameter int ADDR_W = 25,
   parameter int DATA_W = 16
);
   logic              initddr;
   logic [2:0]        cmd;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic              read;
   logic              ready;
   logic              notfull;
   logic              notempty;
   logic [DATA_W-1:0] dout;
   logic [ADDR_W-1:0] raddr;

   modport master (
      output initddr, cmd, addr, din, read,
      input  ready, notfull, notempty, dout, raddr
   );

   modport slave (
      input  initddr, cmd, addr, din, read,
      output ready, notfull, notempty, dout, raddr
   );
endinterface

// File: rtl/ddr2_host_sequencer.sv
// Self-test traffic master for the DDR2 controller: optional init, linear pattern write,
// read-back with in-order data/address checking, and a registered pass/fail report.
module ddr2_host_sequencer #(
   parameter int                ADDR_W      = 25,
   parameter int                DATA_W      = 16,
   parameter int                NW_W        = 10,
   parameter int                ERR_W       = 8,
   parameter logic [2:0]        CMD_NOP     = 3'b000,
   parameter logic [2:0]        CMD_SCR     = 3'b001,
   parameter logic [2:0]        CMD_SCW     = 3'b010,
   parameter logic [DATA_W-1:0] SEED        = 16'hA5A5,
   parameter logic [19:0]       TIMEOUT_CYC = 20'd200000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [NW_W-1:0]      num_words,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 timeout,
   output logic [ERR_W-1:0]     err_count,
   ddr2_host_sequencer_if.master bus
);

   typedef enum logic [2:0] {IDLE, INIT, WRITE, READ, DRAIN, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] base_q;
   logic [NW_W-1:0]   num_q;
   logic [NW_W-1:0]   idx;
   logic [NW_W-1:0]   pops;
   logic [NW_W-1:0]   checked;
   logic [19:0]       tcnt;
   logic              read_d;

   logic [ADDR_W-1:0] issue_addr;
   logic [ADDR_W-1:0] exp_addr;
   logic              last_issue;
   logic              checking;
   logic              last_check;
   logic              mismatch;
   logic [ERR_W-1:0]  err_next;
   logic              pop_now;

   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
      return a[DATA_W-1:0] ^ SEED;
   endfunction

   always_comb begin
      issue_addr = base_q + ADDR_W'(idx);
      exp_addr   = base_q + ADDR_W'(checked);
      last_issue = (idx + NW_W'(1)) == num_q;
      checking   = read_d && (state == READ || state == DRAIN);
      last_check = checking && ((checked + NW_W'(1)) == num_q);
      mismatch   = (bus.dout != pattern(exp_addr)) || (bus.raddr != exp_addr);
      err_next   = err_count;
      if (checking && mismatch && (err_count != {ERR_W{1'b1}}))
         err_next = err_count + ERR_W'(1);
      // read is registered, so the FIFO's notempty lags a pop by a cycle; never pop back-to-back
      pop_now = (state == READ || state == DRAIN) && bus.notempty && !bus.read && (pops != num_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         bus.initddr <= 1'b0;
         bus.cmd     <= CMD_NOP;
         bus.addr    <= '0;
         bus.din     <= '0;
         bus.read    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         timeout     <= 1'b0;
         err_count   <= '0;
         base_q      <= '0;
         num_q       <= '0;
         idx         <= '0;
         pops        <= '0;
         checked     <= '0;
         tcnt        <= '0;
         read_d      <= 1'b0;
      end else begin
         read_d   <= bus.read;
         bus.read <= pop_now;
         if (pop_now)
            pops <= pops + NW_W'(1);
         if (checking) begin
            checked   <= checked + NW_W'(1);
            err_count <= err_next;
         end

         case (state)
            IDLE, DONE: begin
               bus.cmd  <= CMD_NOP;
               bus.read <= 1'b0;
               if (start) begin
                  base_q    <= base_addr;
                  num_q     <= num_words;
                  idx       <= '0;
                  pops      <= '0;
                  checked   <= '0;
                  tcnt      <= '0;
                  err_count <= '0;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  timeout   <= 1'b0;
                  if (!bus.ready) begin
                     state       <= INIT;
                     bus.initddr <= 1'b1;
                     busy        <= 1'b1;
                  end else if (num_words == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= WRITE;
                     busy  <= 1'b1;
                  end
               end
            end

            INIT: begin
               tcnt <= tcnt + 20'd1;
               if (bus.ready) begin
                  bus.initddr <= 1'b0;
                  if (num_q == '0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= WRITE;
                  end
               end else if (tcnt == TIMEOUT_CYC) begin
                  state       <= DONE;
                  bus.initddr <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  pass        <= 1'b0;
                  timeout     <= 1'b1;
               end
            end

            WRITE: begin
               if (bus.notfull) begin
                  bus.cmd  <= CMD_SCW;
                  bus.addr <= issue_addr;
                  bus.din  <= pattern(issue_addr);
                  if (last_issue) begin
                     idx   <= '0;
                     state <= READ;
                  end else begin
                     idx <= idx + NW_W'(1);
                  end
               end else begin
                  bus.cmd <= CMD_NOP;
               end
            end

            READ: begin
               if (bus.notfull) begin
                  bus.cmd  <= CMD_SCR;
                  bus.addr <= issue_addr;
                  bus.din  <= '0;
                  if (last_issue) begin
                     idx   <= '0;
                     tcnt  <= '0;
                     state <= DRAIN;
                  end else begin
                     idx <= idx + NW_W'(1);
                  end
               end else begin
                  bus.cmd <= CMD_NOP;
               end
            end

            DRAIN: begin
               bus.cmd <= CMD_NOP;
               tcnt    <= tcnt + 20'd1;
               if (last_check) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  pass     <= (err_next == '0);
                  bus.read <= 1'b0;
               end else if (tcnt == TIMEOUT_CYC) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  pass     <= 1'b0;
                  timeout  <= 1'b1;
                  bus.read <= 1'b0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr2_host_sequencer.sv
// Directed bench for ddr2_host_sequencer with a loopback controller model and a
// command scoreboard fed by the stimulus and drained as commands appear on the bus.
module tb_ddr2_host_sequencer;

   localparam logic [2:0] NOP = 3'b000;
   localparam logic [2:0] SCR = 3'b001;
   localparam logic [2:0] SCW = 3'b010;

   typedef struct {
      logic [2:0]  cmd;
      logic [24:0] addr;
      logic [15:0] din;
   } exp_t;

   typedef struct {
      logic [24:0] addr;
      logic [15:0] data;
   } ret_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [24:0] base_addr;
   logic [9:0]  num_words;
   logic        busy, done, pass, timeout;
   logic [7:0]  err_count;

   int ncmp  = 0;
   int nfail = 0;

   exp_t        sbq[$];
   ret_t        rq[$];
   ret_t        r;
   logic [15:0] mem [logic [24:0]];
   logic        corrupt_en   = 1'b0;
   logic [24:0] corrupt_addr = '0;

   ddr2_host_sequencer_if #(.ADDR_W(25), .DATA_W(16)) bus ();

   ddr2_host_sequencer #(.TIMEOUT_CYC(20'd1000)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .timeout   (timeout),
      .err_count (err_count),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Loopback controller: stores writes, queues reads, returns one word per pop
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         rq.delete();
         bus.notempty <= 1'b0;
         bus.dout     <= '0;
         bus.raddr    <= '0;
      end else begin
         if (bus.read && rq.size() != 0) begin
            r = rq.pop_front();
            bus.dout  <= r.data;
            bus.raddr <= r.addr;
         end
         if (bus.cmd == SCW) begin
            mem[bus.addr] = bus.din;
         end else if (bus.cmd == SCR) begin
            r.addr = bus.addr;
            r.data = mem.exists(bus.addr) ? mem[bus.addr] : 16'h0000;
            if (corrupt_en && bus.addr == corrupt_addr)
               r.data = r.data ^ 16'h0001;
            rq.push_back(r);
         end
         bus.notempty <= (rq.size() != 0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (reset && bus.cmd != NOP) begin
         check("cmd_expected", 32'(sbq.size() != 0), 32'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("cmd",  32'(bus.cmd),  32'(e.cmd));
            check("addr", 32'(bus.addr), 32'(e.addr));
            check("din",  32'(bus.din),  32'(e.din));
         end
      end
   end

   task automatic push_exp(input logic [24:0] base, input int num);
      logic [24:0] a;
      for (int i = 0; i < num; i++) begin
         a = base + 25'(i);
         sbq.push_back('{SCW, a, a[15:0] ^ 16'hA5A5});
      end
      for (int i = 0; i < num; i++) begin
         a = base + 25'(i);
         sbq.push_back('{SCR, a, 16'h0000});
      end
   endtask

   task automatic pulse_start(input logic [24:0] base, input logic [9:0] num);
      @(posedge clk); #1;
      base_addr = base;
      num_words = num;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, input string tag);
      int n = 0;
      while (!done && n < maxc) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic check_result(input string tag, input logic exp_pass, input logic [7:0] exp_err,
                               input logic exp_to);
      check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
      check({tag, "_err"},  32'(err_count), 32'(exp_err));
      check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
      check({tag, "_sb_empty"}, 32'(sbq.size()), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cmd"},     32'(bus.cmd), 32'(NOP));
      check({tag, "_addr"},    32'(bus.addr), 32'd0);
      check({tag, "_din"},     32'(bus.din), 32'd0);
      check({tag, "_flags"},   32'({bus.initddr, bus.read, busy, done, pass, timeout}), 32'd0);
      check({tag, "_err"},     32'(err_count), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b0;
      start       = 1'b0;
      base_addr   = '0;
      num_words   = '0;
      bus.ready   = 1'b0;
      bus.notfull = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      reset = 1'b1;

      // Init handshake then basic 4-word run
      push_exp(25'h0000010, 4);
      pulse_start(25'h0000010, 10'd4);
      for (int i = 0; i < 99; i++) begin
         check("init_hold", 32'(bus.initddr), 32'd1);
         @(posedge clk); #1;
      end
      bus.ready = 1'b1;
      @(posedge clk); #1;
      check("init_drop", 32'(bus.initddr), 32'd0);
      @(posedge clk); #1;
      check("first_cmd",  32'(bus.cmd), 32'(SCW));
      check("first_addr", 32'(bus.addr), 32'h0000010);
      check("first_din",  32'(bus.din), 32'h0000A5B5);
      wait_done(200, "basic");
      check_result("basic", 1'b1, 8'd0, 1'b0);

      // Back-pressure mid-WRITE
      push_exp(25'h0000100, 8);
      pulse_start(25'h0000100, 10'd8);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.notfull = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("stall_nop", 32'(bus.cmd), 32'(NOP));
      end
      bus.notfull = 1'b1;
      wait_done(300, "stall");
      check_result("stall", 1'b1, 8'd0, 1'b0);

      // Corrupted word 2
      corrupt_addr = 25'h0000202;
      corrupt_en   = 1'b1;
      push_exp(25'h0000200, 4);
      pulse_start(25'h0000200, 10'd4);
      wait_done(200, "corrupt");
      check_result("corrupt", 1'b0, 8'd1, 1'b0);
      corrupt_en = 1'b0;

      // Address wrap past all-ones
      push_exp(25'h1FFFFFE, 4);
      pulse_start(25'h1FFFFFE, 10'd4);
      wait_done(200, "wrap");
      check_result("wrap", 1'b1, 8'd0, 1'b0);

      // Zero-length run
      pulse_start(25'h0000300, 10'd0);
      check("zero_done", 32'(done), 32'd1);
      check("zero_pass", 32'(pass), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);

      // Ready never rises
      bus.ready = 1'b0;
      pulse_start(25'h0000500, 10'd4);
      check("to_initddr_on", 32'(bus.initddr), 32'd1);
      wait_done(1200, "tmo");
      check_result("tmo", 1'b0, 8'd0, 1'b1);
      check("tmo_initddr", 32'(bus.initddr), 32'd0);
      bus.ready = 1'b1;

      // Reset mid-WRITE
      push_exp(25'h0000400, 50);
      pulse_start(25'h0000400, 10'd50);
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("midrun_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check_reset_vals("midreset");
      sbq.delete();
      @(posedge clk); #1;
      reset = 1'b1;

      // Recovery run after reset
      push_exp(25'h0000040, 2);
      pulse_start(25'h0000040, 10'd2);
      wait_done(200, "recover");
      check_result("recover", 1'b1, 8'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
